// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: free-run at a divided rate or single-step from a
// debounced push button, emitting one-cycle cpu_ce pulses on the board clock.
module cpu_clk_ctrl #(
   parameter int unsigned DIVISOR         = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic        clock_in,
   input  logic        rst,
   input  logic        run_mode,
   input  logic        step_btn,
   input  logic        halt,
   output logic        cpu_ce,
   output logic [1:0]  state,
   output logic [15:0] ce_count
);

   localparam int unsigned DivW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int unsigned DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(DIVISOR - 1);
   localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StStep   = 2'd2,
      StHalted = 2'd3
   } state_e;

   logic            run_meta_q, run_sync_q;
   logic            step_meta_q, step_sync_q;
   logic            db_level_q, db_prev_q;
   logic [DebW-1:0] db_cnt_q;
   logic [DivW-1:0] div_cnt_q;
   state_e          state_q, state_d;
   logic            cpu_ce_q, ce_d;
   logic [15:0]     ce_count_q;

   logic step_req, db_mismatch, db_toggle, run_pulse;

   always_comb begin
      step_req    = db_level_q & ~db_prev_q;
      db_mismatch = step_sync_q != db_level_q;
      db_toggle   = db_mismatch && (db_cnt_q == DebLast);

      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (step_req) begin
               state_d = StStep;
            end else if (run_sync_q && !halt) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (halt) begin
               state_d = StHalted;
            end else if (!run_sync_q) begin
               state_d = StIdle;
            end
         end
         StStep:   state_d = halt ? StHalted : StIdle;
         StHalted: state_d = run_sync_q ? StHalted : StIdle;
      endcase

      run_pulse = (state_q == StRun) && (div_cnt_q == DivLast) && !halt && run_sync_q;
      ce_d      = (state_d == StStep) || run_pulse;
   end

   always_ff @(posedge clock_in or negedge rst) begin
      if (!rst) begin
         run_meta_q  <= 1'b0;
         run_sync_q  <= 1'b0;
         step_meta_q <= 1'b0;
         step_sync_q <= 1'b0;
         db_level_q  <= 1'b0;
         db_prev_q   <= 1'b0;
         db_cnt_q    <= '0;
         div_cnt_q   <= '0;
         state_q     <= StIdle;
         cpu_ce_q    <= 1'b0;
         ce_count_q  <= 16'd0;
      end else begin
         run_meta_q  <= run_mode;
         run_sync_q  <= run_meta_q;
         step_meta_q <= step_btn;
         step_sync_q <= step_meta_q;

         // Counter tracks consecutive edges the synced button disagrees with the level.
         if (!db_mismatch || db_toggle) begin
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end
         if (db_toggle) begin
            db_level_q <= ~db_level_q;
         end
         db_prev_q <= db_level_q;

         // Only advances while staying in RUN, so every RUN entry restarts the period.
         if ((state_q == StRun) && (state_d == StRun)) begin
            div_cnt_q <= (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;
         end else begin
            div_cnt_q <= '0;
         end

         state_q    <= state_d;
         cpu_ce_q   <= ce_d;
         ce_count_q <= ce_count_q + {15'd0, ce_d};
      end
   end

   assign cpu_ce   = cpu_ce_q;
   assign state    = state_q;
   assign ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: DIVISOR=3 and DIVISOR=1 instances, both with
// DEBOUNCE_CYCLES=4, checked cycle by cycle against a behavioural model.
module tb_cpu_clk_ctrl;

   localparam int Deb     = 4;
   localparam int SIdle   = 0;
   localparam int SRun    = 1;
   localparam int SStep   = 2;
   localparam int SHalted = 3;

   logic        clock_in = 1'b0;
   logic        rst      = 1'b0;
   logic        run_in  [2];
   logic        step_in [2];
   logic        halt_in [2];
   logic        ce      [2];
   logic [1:0]  st      [2];
   logic [15:0] cnt     [2];

   int n_chk = 0;
   int n_bad = 0;

   // Model state: input history as seen through two sampling stages, a sliding
   // window of the last Deb synced button values, and the abstract run/step state.
   bit m_run_p  [2][2];
   bit m_step_p [2][2];
   bit m_win    [2][Deb];
   bit m_lvl    [2];
   bit m_rose   [2];
   int m_state  [2];
   int m_edge   [2];
   int m_run_start [2];
   int m_cnt    [2];
   bit m_ce     [2];

   always #5 clock_in = ~clock_in;

   cpu_clk_ctrl #(.DIVISOR(3), .DEBOUNCE_CYCLES(Deb)) dut_a (
      .clock_in (clock_in),
      .rst      (rst),
      .run_mode (run_in[0]),
      .step_btn (step_in[0]),
      .halt     (halt_in[0]),
      .cpu_ce   (ce[0]),
      .state    (st[0]),
      .ce_count (cnt[0])
   );

   cpu_clk_ctrl #(.DIVISOR(1), .DEBOUNCE_CYCLES(Deb)) dut_b (
      .clock_in (clock_in),
      .rst      (rst),
      .run_mode (run_in[1]),
      .step_btn (step_in[1]),
      .halt     (halt_in[1]),
      .cpu_ce   (ce[1]),
      .state    (st[1]),
      .ce_count (cnt[1])
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int i);
      for (int j = 0; j < 2; j++) begin
         m_run_p[i][j]  = 1'b0;
         m_step_p[i][j] = 1'b0;
      end
      for (int j = 0; j < Deb; j++) m_win[i][j] = 1'b0;
      m_lvl[i]       = 1'b0;
      m_rose[i]      = 1'b0;
      m_state[i]     = SIdle;
      m_edge[i]      = 0;
      m_run_start[i] = 0;
      m_cnt[i]       = 0;
      m_ce[i]        = 1'b0;
   endtask

   task automatic model_step(input int i, input int div);
      bit rs, ss, req, tog, pulse;
      int nxt;
      m_edge[i]++;
      rs = m_run_p[i][1];
      ss = m_step_p[i][1];
      m_run_p[i][1]  = m_run_p[i][0];
      m_run_p[i][0]  = run_in[i];
      m_step_p[i][1] = m_step_p[i][0];
      m_step_p[i][0] = step_in[i];
      for (int j = Deb - 1; j > 0; j--) m_win[i][j] = m_win[i][j-1];
      m_win[i][0] = ss;
      // Level flips once the last Deb synced samples all disagree with it.
      tog = 1'b1;
      for (int j = 0; j < Deb; j++) if (m_win[i][j] == m_lvl[i]) tog = 1'b0;
      req       = m_rose[i];
      m_rose[i] = tog && !m_lvl[i];
      if (tog) m_lvl[i] = !m_lvl[i];

      nxt = m_state[i];
      case (m_state[i])
         SIdle:   if (req) nxt = SStep; else if (rs && !halt_in[i]) nxt = SRun;
         SRun:    if (halt_in[i]) nxt = SHalted; else if (!rs) nxt = SIdle;
         SStep:   nxt = halt_in[i] ? SHalted : SIdle;
         default: if (!rs) nxt = SIdle;
      endcase
      pulse = (nxt == SStep) ||
              (m_state[i] == SRun && ((m_edge[i] - m_run_start[i]) % div) == 0 &&
               !halt_in[i] && rs);
      if (m_state[i] != SRun && nxt == SRun) m_run_start[i] = m_edge[i];
      m_state[i] = nxt;
      m_ce[i]    = pulse;
      m_cnt[i]   = (m_cnt[i] + int'(pulse)) % 65536;
   endtask

   task automatic tick();
      @(posedge clock_in);
      if (rst) begin
         model_step(0, 3);
         model_step(1, 1);
      end
      @(negedge clock_in);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("ce[%0d]", i), int'(ce[i]), int'(m_ce[i]));
         chk($sformatf("state[%0d]", i), int'(st[i]), m_state[i]);
         chk($sformatf("count[%0d]", i), int'(cnt[i]), m_cnt[i]);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int first, pulses, base, st_pulse, st_after, seg_left, hits;
      bit seen, got_after, found;
      bit pat [8];

      for (int i = 0; i < 2; i++) begin
         run_in[i] = 1'b0; step_in[i] = 1'b0; halt_in[i] = 1'b0;
         model_reset(i);
      end
      ticks(3);
      rst = 1'b1;

      // Reset: assert mid-cycle with inputs toggling, outputs clear without an edge.
      for (int k = 0; k < 20; k++) begin
         run_in[0]  = 1'($urandom_range(0, 1));
         step_in[0] = 1'($urandom_range(0, 1));
         tick();
      end
      #2 rst = 1'b0;
      #1;
      chk("rst_ce", int'(ce[0]), 0);
      chk("rst_state", int'(st[0]), SIdle);
      chk("rst_count", int'(cnt[0]), 0);
      for (int i = 0; i < 2; i++) model_reset(i);
      for (int k = 0; k < 4; k++) begin
         run_in[0]  = 1'($urandom_range(0, 1));
         step_in[0] = 1'($urandom_range(0, 1));
         halt_in[0] = 1'($urandom_range(0, 1));
         tick();
      end
      run_in[0] = 1'b0; step_in[0] = 1'b0; halt_in[0] = 1'b0;
      rst = 1'b1;
      ticks(10);
      chk("rst_idle_count", int'(cnt[0]), 0);

      // Single step: held press gives one pulse on the 7th edge from the first sample.
      step_in[0] = 1'b1;
      first = 0; pulses = 0; st_pulse = -1;
      for (int e = 1; e <= 30; e++) begin
         tick();
         if (ce[0]) begin
            pulses++;
            if (first == 0) begin first = e; st_pulse = int'(st[0]); end
         end
      end
      chk("step_latency", first, Deb + 3);
      chk("step_pulses", pulses, 1);
      chk("step_state", st_pulse, SStep);
      chk("step_count1", int'(cnt[0]), 1);
      step_in[0] = 1'b0; ticks(12);
      step_in[0] = 1'b1; ticks(12);
      step_in[0] = 1'b0; ticks(12);
      chk("step_count2", int'(cnt[0]), 2);

      // Bounce rejection: no run of Deb consecutive 1s, so no pulse.
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      base = int'(cnt[0]);
      for (int k = 0; k < 8; k++) begin step_in[0] = pat[k]; tick(); end
      step_in[0] = 1'b0; ticks(12);
      chk("bounce_pulses", int'(cnt[0]) - base, 0);
      step_in[0] = 1'b1; ticks(12);
      step_in[0] = 1'b0; ticks(12);
      chk("bounce_clean", int'(cnt[0]) - base, 1);

      // Free run at DIVISOR=3.
      run_in[0] = 1'b1;
      ticks(3);
      chk("run_entry", int'(st[0]), SRun);
      pulses = 0;
      for (int k = 0; k < 30; k++) begin tick(); pulses += int'(ce[0]); end
      chk("run_pulses", pulses, 10);
      base = int'(cnt[0]);
      step_in[0] = 1'b1; ticks(12);
      step_in[0] = 1'b0; ticks(12);
      chk("run_step_extra", int'(cnt[0]) - base, 8);
      run_in[0] = 1'b0;
      ticks(3);
      chk("run_exit", int'(st[0]), SIdle);
      base = int'(cnt[0]);
      ticks(10);
      chk("run_stopped", int'(cnt[0]) - base, 0);

      // Halt lands on the edge that would carry a RUN pulse.
      run_in[0] = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick();
         if (m_state[0] == SRun && ((m_edge[0] + 1 - m_run_start[0]) % 3) == 0 &&
             m_edge[0] - m_run_start[0] > 3) found = 1'b1;
      end
      chk("halt_align", int'(found), 1);
      halt_in[0] = 1'b1;
      tick();
      chk("halt_ce", int'(ce[0]), 0);
      chk("halt_state", int'(st[0]), SHalted);
      base = int'(cnt[0]);
      ticks(10);
      step_in[0] = 1'b1; ticks(12);
      step_in[0] = 1'b0; ticks(12);
      chk("halt_ignored", int'(cnt[0]) - base, 0);
      run_in[0] = 1'b0;
      ticks(3);
      chk("halt_to_idle", int'(st[0]), SIdle);
      step_in[0] = 1'b1;
      seen = 1'b0; got_after = 1'b0; st_after = -1; pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (seen && !got_after) begin st_after = int'(st[0]); got_after = 1'b1; end
         if (ce[0]) begin seen = 1'b1; pulses++; end
      end
      step_in[0] = 1'b0; ticks(12);
      chk("halt_step_pulses", pulses, 1);
      chk("halt_step_state", st_after, SHalted);
      halt_in[0] = 1'b0;
      ticks(4);

      // Random bouncy button, run switch and halt, checked against the model each cycle.
      seg_left = 0;
      for (int k = 0; k < 4000; k++) begin
         if (seg_left == 0) begin
            step_in[0] = 1'($urandom_range(0, 1));
            seg_left   = int'($urandom_range(1, 9));
         end
         seg_left--;
         if ($urandom_range(0, 99) < 3) run_in[0] = ~run_in[0];
         halt_in[0] = ($urandom_range(0, 19) == 0);
         tick();
      end
      run_in[0] = 1'b0; step_in[0] = 1'b0; halt_in[0] = 1'b0;
      ticks(12);

      // DIVISOR=1: continuous enable, 16-bit count wraps.
      run_in[1] = 1'b1;
      ticks(3);
      hits = 0;
      for (int k = 0; k < 65541; k++) begin tick(); hits += int'(ce[1]); end
      chk("wrap_pulses", hits, 65541);
      chk("wrap_count", int'(cnt[1]), 5);
      run_in[1] = 1'b0;
      ticks(5);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
